// File: rtl/frame_stack.sv
// frame_stack: WebAssembly operand stack with a frame-base stack for CALL/RETURN.
// Locals are addressed relative to the current base; a non-trivial RETURN copies its results down over several cycles.
module frame_stack #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 3,
    parameter int FRAME_DEPTH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [2:0]             op,
    input  logic [WIDTH-1:0]       data,
    input  logic [DEPTH:0]         offset,
    input  logic [DEPTH:0]         results,
    output logic                   ready,
    output logic [DEPTH:0]         index,
    output logic [DEPTH:0]         base,
    output logic [FRAME_DEPTH:0]   frame,
    output logic [WIDTH-1:0]       out,
    output logic [WIDTH-1:0]       out1,
    output logic [2:0]             status
);
    localparam int ENTRIES = 1 << DEPTH;
    localparam int FRAMES  = 1 << FRAME_DEPTH;

    localparam logic [DEPTH:0]       IDX_ZERO  = (DEPTH+1)'(0);
    localparam logic [DEPTH:0]       IDX_ONE   = (DEPTH+1)'(1);
    localparam logic [DEPTH:0]       IDX_TWO   = (DEPTH+1)'(2);
    localparam logic [DEPTH:0]       IDX_FULL  = (DEPTH+1)'(ENTRIES);
    localparam logic [DEPTH-1:0]     ADDR_ONE  = DEPTH'(1);
    localparam logic [DEPTH-1:0]     ADDR_TWO  = DEPTH'(2);
    localparam logic [FRAME_DEPTH:0] FRM_ZERO  = (FRAME_DEPTH+1)'(0);
    localparam logic [FRAME_DEPTH:0] FRM_ONE   = (FRAME_DEPTH+1)'(1);
    localparam logic [FRAME_DEPTH:0] FRM_FULL  = (FRAME_DEPTH+1)'(FRAMES);

    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_CALL    = 3'd4;
    localparam logic [2:0] OP_RETURN  = 3'd5;
    localparam logic [2:0] OP_GET     = 3'd6;
    localparam logic [2:0] OP_SET     = 3'd7;

    localparam logic [2:0] ST_NONE      = 3'd0;
    localparam logic [2:0] ST_EMPTY     = 3'd1;
    localparam logic [2:0] ST_FULL      = 3'd2;
    localparam logic [2:0] ST_UNDERFLOW = 3'd3;
    localparam logic [2:0] ST_OVERFLOW  = 3'd4;
    localparam logic [2:0] ST_FRAME_OVF = 3'd5;
    localparam logic [2:0] ST_FRAME_UNF = 3'd6;
    localparam logic [2:0] ST_BAD_OFS   = 3'd7;

    typedef enum logic {S_IDLE = 1'b0, S_COPY = 1'b1} state_e;

    logic [WIDTH-1:0]     mem_r   [ENTRIES];
    logic [DEPTH:0]       saved_r [FRAMES];
    logic [DEPTH:0]       index_r;
    logic [DEPTH:0]       base_r;
    logic [FRAME_DEPTH:0] frame_r;
    logic [2:0]           status_r;
    state_e               state_r;
    logic [DEPTH-1:0]     src_r;
    logic [DEPTH:0]       cnt_r;
    logic [DEPTH:0]       res_r;

    state_e               state_s;
    logic                 ready_s;
    logic                 accept_s;
    logic [DEPTH:0]       index_s;
    logic [DEPTH:0]       base_s;
    logic [FRAME_DEPTH:0] frame_s;
    logic [2:0]           status_s;
    logic                 mem_we_s;
    logic [DEPTH-1:0]     mem_waddr_s;
    logic [WIDTH-1:0]     mem_wdata_s;
    logic                 save_we_s;
    logic                 copy_start_s;
    logic                 copy_last_s;
    logic [DEPTH:0]       avail_s;
    logic [DEPTH+1:0]     loc_sum_s;
    logic                 loc_bad_s;
    logic [DEPTH-1:0]     loc_addr_s;
    logic [DEPTH:0]       inc_idx_s;
    logic [DEPTH:0]       dec_idx_s;
    logic [DEPTH-1:0]     top_addr_s;
    logic [DEPTH-1:0]     sec_addr_s;
    logic [DEPTH:0]       call_base_s;
    logic [DEPTH:0]       ret_gap_s;
    logic                 ret_trivial_s;
    logic [FRAME_DEPTH:0] frm_dec_s;
    logic [DEPTH:0]       pop_base_s;
    logic [DEPTH:0]       trivial_idx_s;
    logic [DEPTH:0]       commit_idx_s;
    logic [DEPTH-1:0]     cp_dst_s;
    logic [DEPTH-1:0]     cp_src_s;

    function automatic logic [2:0] eval_status(input logic [DEPTH:0] idx, input logic [DEPTH:0] bas);
        if (idx == bas) begin
            return ST_EMPTY;
        end else if (idx == IDX_FULL) begin
            return ST_FULL;
        end else begin
            return ST_NONE;
        end
    endfunction

    // Address and bound arithmetic shared by all ops; index_r >= base_r always holds.
    always_comb begin
        accept_s      = valid && ready_s;
        avail_s       = index_r - base_r;
        loc_sum_s     = {1'b0, base_r} + {1'b0, offset};
        loc_bad_s     = (loc_sum_s >= {1'b0, index_r});
        loc_addr_s    = loc_sum_s[DEPTH-1:0];
        inc_idx_s     = index_r + IDX_ONE;
        dec_idx_s     = index_r - IDX_ONE;
        top_addr_s    = index_r[DEPTH-1:0] - ADDR_ONE;
        sec_addr_s    = index_r[DEPTH-1:0] - ADDR_TWO;
        call_base_s   = index_r - offset;
        ret_gap_s     = index_r - results;
        ret_trivial_s = (results == IDX_ZERO) || (ret_gap_s == base_r);
        frm_dec_s     = frame_r - FRM_ONE;
        pop_base_s    = saved_r[frm_dec_s[FRAME_DEPTH-1:0]];
        trivial_idx_s = base_r + results;
        commit_idx_s  = base_r + res_r;
        copy_last_s   = (cnt_r == (res_r - IDX_ONE));
        cp_dst_s      = base_r[DEPTH-1:0] + cnt_r[DEPTH-1:0];
        cp_src_s      = src_r + cnt_r[DEPTH-1:0];
    end

    // Per-op next state, memory write port and status; failed checks change only status.
    always_comb begin
        index_s      = index_r;
        base_s       = base_r;
        frame_s      = frame_r;
        status_s     = status_r;
        mem_we_s     = 1'b0;
        mem_waddr_s  = index_r[DEPTH-1:0];
        mem_wdata_s  = data;
        save_we_s    = 1'b0;
        copy_start_s = 1'b0;
        if (state_r == S_COPY) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cp_dst_s;
            mem_wdata_s = mem_r[cp_src_s];
            if (copy_last_s) begin
                index_s  = commit_idx_s;
                base_s   = pop_base_s;
                frame_s  = frm_dec_s;
                status_s = eval_status(commit_idx_s, pop_base_s);
            end else begin
                status_s = status_r;
            end
        end else if (accept_s) begin
            case (op)
                OP_PUSH: begin
                    if (index_r == IDX_FULL) begin
                        status_s = ST_OVERFLOW;
                    end else begin
                        mem_we_s = 1'b1;
                        index_s  = inc_idx_s;
                        status_s = eval_status(inc_idx_s, base_r);
                    end
                end
                OP_POP: begin
                    if (index_r <= base_r) begin
                        status_s = ST_UNDERFLOW;
                    end else begin
                        index_s  = dec_idx_s;
                        status_s = eval_status(dec_idx_s, base_r);
                    end
                end
                OP_REPLACE: begin
                    if (index_r <= base_r) begin
                        status_s = ST_UNDERFLOW;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = top_addr_s;
                        status_s    = eval_status(index_r, base_r);
                    end
                end
                OP_CALL: begin
                    if (frame_r == FRM_FULL) begin
                        status_s = ST_FRAME_OVF;
                    end else if (offset > avail_s) begin
                        status_s = ST_UNDERFLOW;
                    end else begin
                        save_we_s = 1'b1;
                        base_s    = call_base_s;
                        frame_s   = frame_r + FRM_ONE;
                        status_s  = eval_status(index_r, call_base_s);
                    end
                end
                OP_RETURN: begin
                    if (frame_r == FRM_ZERO) begin
                        status_s = ST_FRAME_UNF;
                    end else if (results > avail_s) begin
                        status_s = ST_UNDERFLOW;
                    end else if (ret_trivial_s) begin
                        index_s  = trivial_idx_s;
                        base_s   = pop_base_s;
                        frame_s  = frm_dec_s;
                        status_s = eval_status(trivial_idx_s, pop_base_s);
                    end else begin
                        copy_start_s = 1'b1;
                    end
                end
                OP_GET: begin
                    if (loc_bad_s) begin
                        status_s = ST_BAD_OFS;
                    end else if (index_r == IDX_FULL) begin
                        status_s = ST_OVERFLOW;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_wdata_s = mem_r[loc_addr_s];
                        index_s     = inc_idx_s;
                        status_s    = eval_status(inc_idx_s, base_r);
                    end
                end
                OP_SET: begin
                    if (loc_bad_s) begin
                        status_s = ST_BAD_OFS;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = loc_addr_s;
                        status_s    = eval_status(index_r, base_r);
                    end
                end
                default: status_s = eval_status(index_r, base_r);
            endcase
        end else begin
            status_s = status_r;
        end
    end

    // FSM next state: a non-trivial RETURN enters COPY until its last element moves.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (copy_start_s) state_s = S_COPY;
                else state_s = S_IDLE;
            end
            S_COPY: begin
                if (copy_last_s) state_s = S_IDLE;
                else state_s = S_COPY;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        case (state_r)
            S_IDLE:  ready_s = 1'b1;
            S_COPY:  ready_s = 1'b0;
            default: ready_s = 1'b1;
        endcase
    end

    // State register, stack pointers, saved bases and latched RETURN parameters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            index_r  <= IDX_ZERO;
            base_r   <= IDX_ZERO;
            frame_r  <= FRM_ZERO;
            status_r <= ST_EMPTY;
            src_r    <= {DEPTH{1'b0}};
            cnt_r    <= IDX_ZERO;
            res_r    <= IDX_ZERO;
            for (int i = 0; i < FRAMES; i++) begin
                saved_r[i] <= IDX_ZERO;
            end
        end else begin
            state_r  <= state_s;
            index_r  <= index_s;
            base_r   <= base_s;
            frame_r  <= frame_s;
            status_r <= status_s;
            if (save_we_s) begin
                saved_r[frame_r[FRAME_DEPTH-1:0]] <= base_r;
            end
            if (copy_start_s) begin
                src_r <= ret_gap_s[DEPTH-1:0];
                res_r <= results;
                cnt_r <= IDX_ZERO;
            end else if (state_r == S_COPY) begin
                cnt_r <= cnt_r + IDX_ONE;
            end
        end
    end

    // Operand storage is deliberately not cleared; reset only suppresses writes.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Top-of-stack views.
    always_comb begin
        if (index_r == IDX_ZERO) out = {WIDTH{1'b0}};
        else out = mem_r[top_addr_s];
        if (index_r < IDX_TWO) out1 = {WIDTH{1'b0}};
        else out1 = mem_r[sec_addr_s];
    end

    assign ready  = ready_s;
    assign index  = index_r;
    assign base   = base_r;
    assign frame  = frame_r;
    assign status = status_r;

endmodule

// File: tb/tb_frame_stack.sv
// Directed bench for frame_stack (WIDTH=8, DEPTH=3, FRAME_DEPTH=1).
module tb_frame_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int FRAME_DEPTH = 1;

    localparam logic [2:0] OP_NONE = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4, OP_RETURN = 3'd5, OP_GET = 3'd6, OP_SET = 3'd7;
    localparam logic [2:0] ST_NONE = 3'd0, ST_EMPTY = 3'd1, ST_FULL = 3'd2, ST_UNDERFLOW = 3'd3;
    localparam logic [2:0] ST_OVERFLOW = 3'd4, ST_FRAME_OVF = 3'd5, ST_FRAME_UNF = 3'd6, ST_BAD_OFS = 3'd7;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   valid = 1'b0;
    logic [2:0]             op = 3'd0;
    logic [WIDTH-1:0]       data = 8'd0;
    logic [DEPTH:0]         offset = 4'd0;
    logic [DEPTH:0]         results = 4'd0;
    logic                   ready;
    logic [DEPTH:0]         index;
    logic [DEPTH:0]         base;
    logic [FRAME_DEPTH:0]   frame;
    logic [WIDTH-1:0]       out;
    logic [WIDTH-1:0]       out1;
    logic [2:0]             status;

    int n_vec = 0;
    int n_err = 0;

    frame_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAME_DEPTH(FRAME_DEPTH)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .data(data),
        .offset(offset), .results(results), .ready(ready), .index(index),
        .base(base), .frame(frame), .out(out), .out1(out1), .status(status)
    );

    always #5 clk = ~clk;

    // One accepted op; returns at the falling edge after the accepting edge.
    task automatic apply(input logic [2:0] o, input logic [7:0] d, input logic [3:0] off, input logic [3:0] res);
        @(negedge clk);
        valid = 1'b1; op = o; data = d; offset = off; results = res;
        @(negedge clk);
        valid = 1'b0; op = OP_NONE;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (index !== 4'd0) begin n_err++; $display("FAIL rst_index: got %0d want 0", index); end
        n_vec++; if (base !== 4'd0) begin n_err++; $display("FAIL rst_base: got %0d want 0", base); end
        n_vec++; if (frame !== 2'd0) begin n_err++; $display("FAIL rst_frame: got %0d want 0", frame); end
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", ready); end
        n_vec++; if (status !== ST_EMPTY) begin n_err++; $display("FAIL rst_status: got %0d want %0d", status, ST_EMPTY); end
        n_vec++; if (out !== 8'd0 || out1 !== 8'd0) begin n_err++; $display("FAIL rst_out: got %0d/%0d want 0/0", out, out1); end
        apply(OP_POP, 8'd0, 4'd0, 4'd0);
        n_vec++; if (status !== ST_UNDERFLOW) begin n_err++; $display("FAIL pop_empty_status: got %0d want %0d", status, ST_UNDERFLOW); end
        n_vec++; if (index !== 4'd0 || ready !== 1'b1) begin n_err++; $display("FAIL pop_empty_state: got index %0d ready %0b want 0 1", index, ready); end
        apply(OP_NONE, 8'd0, 4'd0, 4'd0);
        n_vec++; if (status !== ST_EMPTY) begin n_err++; $display("FAIL none_status: got %0d want %0d", status, ST_EMPTY); end
    endtask

    task automatic test_push_full();
        for (int i = 1; i <= 8; i++) apply(OP_PUSH, 8'(i), 4'd0, 4'd0);
        n_vec++; if (index !== 4'd8) begin n_err++; $display("FAIL full_index: got %0d want 8", index); end
        n_vec++; if (status !== ST_FULL) begin n_err++; $display("FAIL full_status: got %0d want %0d", status, ST_FULL); end
        n_vec++; if (out !== 8'd8 || out1 !== 8'd7) begin n_err++; $display("FAIL full_out: got %0d/%0d want 8/7", out, out1); end
        apply(OP_PUSH, 8'd9, 4'd0, 4'd0);
        n_vec++; if (status !== ST_OVERFLOW) begin n_err++; $display("FAIL ovf_status: got %0d want %0d", status, ST_OVERFLOW); end
        n_vec++; if (index !== 4'd8 || out !== 8'd8) begin n_err++; $display("FAIL ovf_state: got index %0d out %0d want 8 8", index, out); end
    endtask

    task automatic test_call_get_set();
        do_reset();
        apply(OP_PUSH, 8'd1, 4'd0, 4'd0);
        apply(OP_PUSH, 8'd2, 4'd0, 4'd0);
        apply(OP_PUSH, 8'd3, 4'd0, 4'd0);
        apply(OP_CALL, 8'd0, 4'd2, 4'd0);
        n_vec++; if (base !== 4'd1 || frame !== 2'd1 || index !== 4'd3) begin n_err++; $display("FAIL call: got base %0d frame %0d index %0d want 1 1 3", base, frame, index); end
        n_vec++; if (status !== ST_NONE) begin n_err++; $display("FAIL call_status: got %0d want %0d", status, ST_NONE); end
        apply(OP_GET, 8'd0, 4'd0, 4'd0);
        n_vec++; if (index !== 4'd4 || out !== 8'd2 || out1 !== 8'd3) begin n_err++; $display("FAIL get: got index %0d out %0d out1 %0d want 4 2 3", index, out, out1); end
        apply(OP_SET, 8'd7, 4'd1, 4'd0);
        n_vec++; if (out1 !== 8'd7 || index !== 4'd4) begin n_err++; $display("FAIL set: got out1 %0d index %0d want 7 4", out1, index); end
        apply(OP_GET, 8'd0, 4'd5, 4'd0);
        n_vec++; if (status !== ST_BAD_OFS || index !== 4'd4) begin n_err++; $display("FAIL get_bad: got status %0d index %0d want %0d 4", status, index, ST_BAD_OFS); end
        apply(OP_REPLACE, 8'd4, 4'd0, 4'd0);
        n_vec++; if (out !== 8'd4 || status !== ST_NONE) begin n_err++; $display("FAIL replace: got out %0d status %0d want 4 0", out, status); end
    endtask

    task automatic test_return_copy();
        int cycles;
        apply(OP_PUSH, 8'd5, 4'd0, 4'd0);
        apply(OP_PUSH, 8'd6, 4'd0, 4'd0);
        n_vec++; if (index !== 4'd6) begin n_err++; $display("FAIL pre_ret_index: got %0d want 6", index); end
        @(negedge clk);
        valid = 1'b1; op = OP_RETURN; results = 4'd2;
        @(negedge clk);
        // a request offered mid-copy must be ignored and the latched count kept
        op = OP_PUSH; data = 8'd99; results = 4'd0;
        n_vec++; if (ready !== 1'b0 || index !== 4'd6) begin n_err++; $display("FAIL copy1: got ready %0b index %0d want 0 6", ready, index); end
        @(negedge clk);
        valid = 1'b0; op = OP_NONE;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL copy2_ready: got %0b want 0", ready); end
        n_vec++; if (index !== 4'd6 || base !== 4'd1 || frame !== 2'd1 || out !== 8'd6 || out1 !== 8'd5) begin
            n_err++; $display("FAIL copy2_hold: got index %0d base %0d frame %0d out %0d out1 %0d want 6 1 1 6 5", index, base, frame, out, out1); end
        cycles = 0;
        while (ready !== 1'b1 && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        n_vec++; if (cycles !== 1) begin n_err++; $display("FAIL ret_latency: got %0d extra cycles want 1", cycles); end
        n_vec++; if (index !== 4'd3 || base !== 4'd0 || frame !== 2'd0) begin n_err++; $display("FAIL ret_commit: got index %0d base %0d frame %0d want 3 0 0", index, base, frame); end
        n_vec++; if (out !== 8'd6 || out1 !== 8'd5 || status !== ST_NONE) begin n_err++; $display("FAIL ret_out: got %0d/%0d status %0d want 6/5 0", out, out1, status); end
    endtask

    task automatic test_frame_limits();
        apply(OP_RETURN, 8'd0, 4'd0, 4'd0);
        n_vec++; if (status !== ST_FRAME_UNF || frame !== 2'd0 || index !== 4'd3) begin n_err++; $display("FAIL ret_frame0: got status %0d frame %0d index %0d want %0d 0 3", status, frame, index, ST_FRAME_UNF); end
        apply(OP_CALL, 8'd0, 4'd0, 4'd0);
        n_vec++; if (base !== 4'd3 || frame !== 2'd1 || status !== ST_EMPTY) begin n_err++; $display("FAIL call0: got base %0d frame %0d status %0d want 3 1 1", base, frame, status); end
        apply(OP_POP, 8'd0, 4'd0, 4'd0);
        n_vec++; if (status !== ST_UNDERFLOW || index !== 4'd3) begin n_err++; $display("FAIL pop_base: got status %0d index %0d want 3 3", status, index); end
        apply(OP_PUSH, 8'd9, 4'd0, 4'd0);
        apply(OP_CALL, 8'd0, 4'd3, 4'd0);
        n_vec++; if (status !== ST_UNDERFLOW || base !== 4'd3 || frame !== 2'd1) begin n_err++; $display("FAIL call_unf: got status %0d base %0d frame %0d want 3 3 1", status, base, frame); end
        apply(OP_CALL, 8'd0, 4'd0, 4'd0);
        n_vec++; if (base !== 4'd4 || frame !== 2'd2) begin n_err++; $display("FAIL call2: got base %0d frame %0d want 4 2", base, frame); end
        apply(OP_CALL, 8'd0, 4'd0, 4'd0);
        n_vec++; if (status !== ST_FRAME_OVF || frame !== 2'd2 || base !== 4'd4) begin n_err++; $display("FAIL call_ovf: got status %0d frame %0d base %0d want %0d 2 4", status, frame, base, ST_FRAME_OVF); end
        apply(OP_RETURN, 8'd0, 4'd0, 4'd0);
        n_vec++; if (ready !== 1'b1 || index !== 4'd4 || base !== 4'd3 || frame !== 2'd1 || status !== ST_NONE) begin
            n_err++; $display("FAIL ret_zero: got ready %0b index %0d base %0d frame %0d status %0d want 1 4 3 1 0", ready, index, base, frame, status); end
        apply(OP_RETURN, 8'd0, 4'd0, 4'd1);
        n_vec++; if (ready !== 1'b1 || index !== 4'd4 || base !== 4'd0 || frame !== 2'd0 || out !== 8'd9) begin
            n_err++; $display("FAIL ret_inplace: got ready %0b index %0d base %0d frame %0d out %0d want 1 4 0 0 9", ready, index, base, frame, out); end
    endtask

    task automatic test_reset_mid_copy();
        apply(OP_CALL, 8'd0, 4'd1, 4'd0);
        apply(OP_PUSH, 8'd10, 4'd0, 4'd0);
        apply(OP_PUSH, 8'd11, 4'd0, 4'd0);
        apply(OP_PUSH, 8'd12, 4'd0, 4'd0);
        n_vec++; if (index !== 4'd7 || base !== 4'd3 || frame !== 2'd1) begin n_err++; $display("FAIL pre_rst_copy: got index %0d base %0d frame %0d want 7 3 1", index, base, frame); end
        apply(OP_RETURN, 8'd0, 4'd0, 4'd3);
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_copy_busy: got ready %0b want 0", ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++; if (ready !== 1'b1 || index !== 4'd0 || base !== 4'd0 || frame !== 2'd0 || status !== ST_EMPTY) begin
            n_err++; $display("FAIL rst_copy: got ready %0b index %0d base %0d frame %0d status %0d want 1 0 0 0 1", ready, index, base, frame, status); end
        apply(OP_PUSH, 8'd42, 4'd0, 4'd0);
        n_vec++; if (index !== 4'd1 || out !== 8'd42 || out1 !== 8'd0 || status !== ST_NONE) begin
            n_err++; $display("FAIL post_rst_push: got index %0d out %0d out1 %0d status %0d want 1 42 0 0", index, out, out1, status); end
    endtask

    initial begin
        test_reset();
        test_push_full();
        test_call_get_set();
        test_return_copy();
        test_frame_limits();
        test_reset_mid_copy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
